// File: rtl/char_draw_ctrl_if.sv
// char_draw_ctrl_if: request, offset-table and pixel signals of the sprite draw controller
interface char_draw_ctrl_if;
  logic       start;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] colour;
  logic [4:0] pt_idx;
  logic [3:0] pt_dx;
  logic [4:0] pt_dy;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       plot;
  logic       busy;
  logic       done;
  modport master (
    output start, new_x, new_y, colour, pt_dx, pt_dy,
    input  pt_idx, out_x, out_y, out_colour, plot, busy, done
  );
  modport slave (
    input  start, new_x, new_y, colour, pt_dx, pt_dy,
    output pt_idx, out_x, out_y, out_colour, plot, busy, done
  );
endinterface

// File: rtl/char_draw_ctrl.sv
// char_draw_ctrl: plots a sprite point by point, with an optional erase pass of the previous position (CHAR_ERASE_EN)
module char_draw_ctrl #(
  parameter int         NUM_PTS   = 23,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic             clk,
  input logic             reset,
  char_draw_ctrl_if.slave bus
);
`ifdef CHAR_ERASE_EN
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
`endif
  localparam logic [4:0] LAST = 5'(NUM_PTS);
  state_t     state, state_nx;
  logic [4:0] idx;
  logic [7:0] base_x, cur_x;
  logic [6:0] base_y, cur_y;
  logic [2:0] col;
  logic       accept, last, active, erasing;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
`ifdef CHAR_ERASE_EN
  logic [7:0] prev_x;
  logic [6:0] prev_y;
  logic       has_prev;
`endif
  assign accept = state == IDLE && bus.start;
  assign last   = idx == LAST;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next-state: one point per cycle, erase pass (if any) precedes the draw pass
  always_comb begin
    state_nx = state;
    case (state)
`ifdef CHAR_ERASE_EN
      IDLE:    if (bus.start) state_nx = has_prev ? ERASE : DRAW;
      ERASE:   if (last) state_nx = DRAW;
`else
      IDLE:    if (bus.start) state_nx = DRAW;
`endif
      DRAW:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // outputs and pass-dependent base point; sums carry one extra bit so clipping sees overflow
  always_comb begin
`ifdef CHAR_ERASE_EN
    erasing = state == ERASE;
    cur_x   = erasing ? prev_x : base_x;
    cur_y   = erasing ? prev_y : base_y;
`else
    erasing = 1'b0;
    cur_x   = base_x;
    cur_y   = base_y;
`endif
    active     = erasing || state == DRAW;
    sum_x      = {1'b0, cur_x} + {5'b0, bus.pt_dx};
    sum_y      = {1'b0, cur_y} + {3'b0, bus.pt_dy};
    bus.pt_idx = idx;
    bus.busy   = state != IDLE;
    bus.done   = state == DONE;
  end
  // point counter: 1..NUM_PTS per pass, restarts at 1 between erase and draw, 0 otherwise
  always_ff @(posedge clk)
    idx <= reset ? 5'd0 : accept ? 5'd1 : active ? (last ? (erasing ? 5'd1 : 5'd0) : idx + 5'd1) : 5'd0;
  // request latch
  always_ff @(posedge clk)
    if (reset) begin
      base_x <= '0;
      base_y <= '0;
      col    <= '0;
    end else if (accept) begin
      base_x <= bus.new_x;
      base_y <= bus.new_y;
      col    <= bus.colour;
    end
`ifdef CHAR_ERASE_EN
  // remember where the sprite was drawn so the next request can erase it
  always_ff @(posedge clk)
    if (reset) begin
      prev_x   <= '0;
      prev_y   <= '0;
      has_prev <= 1'b0;
    end else if (state == DONE) begin
      prev_x   <= base_x;
      prev_y   <= base_y;
      has_prev <= 1'b1;
    end
`endif
  // registered pixel output, one cycle behind pt_idx; off-screen points are suppressed
  always_ff @(posedge clk)
    if (reset) begin
      bus.out_x      <= '0;
      bus.out_y      <= '0;
      bus.out_colour <= '0;
      bus.plot       <= 1'b0;
    end else begin
      bus.plot <= active && sum_x <= 9'd159 && sum_y <= 8'd119;
      if (active) begin
        bus.out_x      <= sum_x[7:0];
        bus.out_y      <= sum_y[6:0];
        bus.out_colour <= erasing ? BG_COLOUR : col;
      end
    end
endmodule

// File: tb/tb_char_draw_ctrl.sv
// tb_char_draw_ctrl: directed checks of draw, erase, clipping, busy start and mid-pass reset
module tb_char_draw_ctrl;
  localparam int N = 23;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int done_cyc;
  int idx2;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  char_draw_ctrl_if bus();
  char_draw_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.pt_dx = mode ? 4'd8 : {2'b00, bus.pt_idx[1:0]};
  assign bus.pt_dy = mode ? 5'd8 : bus.pt_idx;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic add_exp(input int bx, input int by, input logic [2:0] c);
    for (int i = 1; i <= N; i++) begin
      int ex, ey;
      ex = bx + (mode ? 8 : i % 4);
      ey = by + (mode ? 8 : i);
      if (ex <= 159 && ey <= 119) exp_q.push_back({8'(ex), 7'(ey), c});
    end
  endtask
  task automatic run_req(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c, input int inj);
    got_q.delete();
    done_cyc = -1;
    idx2 = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.new_x = x;
    bus.new_y = y;
    bus.colour = c;
    for (int k = 2; k <= 120; k++) begin
      @(negedge clk);
      if (k == 2) idx2 = int'(bus.pt_idx);
      if (bus.plot) got_q.push_back({bus.out_x, bus.out_y, bus.out_colour});
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      bus.start = (k == inj);
      if (k == inj) begin
        bus.new_x = x + 8'd30;
        bus.new_y = y + 7'd11;
        bus.colour = ~c;
      end
    end
    bus.start = 1'b0;
  endtask
  task automatic expect_run(input string tag, input int exp_done);
    check({tag, "_nplot"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_pt%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_done_cyc"}, done_cyc, exp_done);
    exp_q.delete();
  endtask
  initial begin
    int hit;
    bus.start = 1'b0;
    bus.new_x = '0;
    bus.new_y = '0;
    bus.colour = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_plot", bus.plot, 0);
    check("rst_idx", bus.pt_idx, 0);
    check("rst_xyc", {bus.out_x, bus.out_y, bus.out_colour}, 0);
    reset = 1'b0;
    add_exp(10, 20, 3'b101);
    run_req(8'd10, 7'd20, 3'b101, 0);
    check("first_idx2", idx2, 1);
    expect_run("first", 25);
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
`ifdef CHAR_ERASE_EN
    add_exp(10, 20, 3'b000);
    add_exp(40, 50, 3'b101);
    run_req(8'd40, 7'd50, 3'b101, 0);
    expect_run("redraw", 48);
`else
    add_exp(40, 50, 3'b101);
    run_req(8'd40, 7'd50, 3'b101, 0);
    expect_run("redraw", 25);
`endif
    do_reset();
    mode = 1'b1;
    run_req(8'd155, 7'd115, 3'b111, 0);
    expect_run("clip", 25);
    mode = 1'b0;
    do_reset();
    add_exp(60, 30, 3'b011);
    run_req(8'd60, 7'd30, 3'b011, 5);
    expect_run("busy_start", 25);
    @(negedge clk);
    bus.start = 1'b1;
    bus.new_x = 8'd10;
    bus.new_y = 7'd20;
    bus.colour = 3'b101;
    hit = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.pt_idx == 5'd12) begin
        hit = 1;
        break;
      end
    end
    check("mid_reach12", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", bus.busy, 0);
    check("mid_plot", bus.plot, 0);
    check("mid_idx", bus.pt_idx, 0);
    reset = 1'b0;
    add_exp(10, 20, 3'b101);
    run_req(8'd10, 7'd20, 3'b101, 0);
    expect_run("after_rst", 25);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/char_draw_ctrl.md
CHAR_DRAW_CTRL -- requirements
Module: char_draw_ctrl

Interface
REQ-001 SHALL have parameter NUM_PTS, default 23, number of sprite points per pass (legal range 1..31).
REQ-002 SHALL have parameter BG_COLOUR, default 3'b000, colour used for erase pixels.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, draw request, sampled only in IDLE.
REQ-006 SHALL have port new_x, input, 8, sprite base x, latched on accepted start.
REQ-007 SHALL have port new_y, input, 7, sprite base y, latched on accepted start.
REQ-008 SHALL have port colour, input, 3, sprite colour, latched on accepted start.
REQ-009 SHALL have port pt_idx, output, 5, current point index to the offset table; 0 when not drawing.
REQ-010 SHALL have port pt_dx, input, 4, x offset for pt_idx, valid combinationally in the same cycle.
REQ-011 SHALL have port pt_dy, input, 5, y offset for pt_idx, valid combinationally in the same cycle.
REQ-012 SHALL have port out_x, output, 8, pixel x to the VGA adapter.
REQ-013 SHALL have port out_y, output, 7, pixel y to the VGA adapter.
REQ-014 SHALL have port out_colour, output, 3, pixel colour.
REQ-015 SHALL have port plot, output, 1, pixel write strobe.
REQ-016 SHALL have port busy, output, 1, high in ERASE/DRAW/DONE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at end of a request.

Function
REQ-018 SHALL implement FSM states IDLE, ERASE, DRAW, DONE.
REQ-019 SHALL, in IDLE with start=1, latch new_x/new_y/colour and go to ERASE if erase is enabled and has_prev=1, else go to DRAW.
REQ-020 SHALL ignore start in every state other than IDLE; latched values unchanged.
REQ-021 SHALL drive pt_idx 1,2,..,NUM_PTS on consecutive cycles in ERASE and in DRAW, one point per cycle, no gaps.
REQ-022 SHALL go ERASE->DRAW after pt_idx=NUM_PTS, restarting pt_idx at 1 the next cycle.
REQ-023 SHALL go DRAW->DONE after pt_idx=NUM_PTS; DONE lasts exactly one cycle, then IDLE.
REQ-024 SHALL register out_x=base_x+pt_dx and out_y=base_y+pt_dy with 1-cycle latency from the pt_idx cycle; base is prev_x/prev_y in ERASE and latched new_x/new_y in DRAW.
REQ-025 SHALL compute sums 1 bit wider than the output; out_x/out_y take the low bits.
REQ-026 SHALL assert plot 1 cycle after each pt_idx cycle, except when the wide sum is x>159 or y>119, in which case plot=0 for that point (clip).
REQ-027 SHALL drive out_colour=BG_COLOUR for ERASE points and the latched colour for DRAW points.
REQ-028 SHALL assert done for one cycle in DONE and copy latched new_x/new_y into prev_x/prev_y, with has_prev set to 1.
REQ-029 SHALL have a request latency of 2*NUM_PTS+2 cycles from start to done with erase, and NUM_PTS+2 cycles without erase (23 points: 48 and 25).

Reset
REQ-030 SHALL, when reset=1 at a rising edge, force IDLE, pt_idx=0, out_x=0, out_y=0, out_colour=0, plot=0, busy=0, done=0, prev_x=0, prev_y=0, has_prev=0.
REQ-031 SHALL let reset override start and abort any in-progress pass; no plot is issued the cycle after reset.

Configuration
REQ-032 SHALL compile in the ERASE state and the prev_x/prev_y/has_prev registers only when CHAR_ERASE_EN is defined.
REQ-033 SHALL, when CHAR_ERASE_EN is undefined, go IDLE->DRAW on every start, never output BG_COLOUR, and use 25-cycle latency for 23 points.

Verification
REQ-034 SHALL verify first draw: reset, start with (10,20), colour 3'b101, offsets dx=i%4, dy=i -> 23 plots at (10+dx,20+dy) colour 101, done at cycle 25, no erase pass.
REQ-035 SHALL verify redraw with CHAR_ERASE_EN: after the REQ-034 case, start with (40,50) -> 23 plots at (10+dx,20+dy) colour 000, then 23 at (40+dx,50+dy), done at cycle 48.
REQ-036 SHALL verify clipping: start with (155,115), dx=8, dy=8 for all points -> plot=0 for all points, done still pulses at cycle 25.
REQ-037 SHALL verify start while busy: pulse start at cycle 5 of a draw with different coordinates -> ignored; plot count and coordinates unchanged.
REQ-038 SHALL verify mid-pass reset: assert reset at pt_idx=12 -> next cycle busy=0, plot=0, pt_idx=0; next start takes the no-erase path (has_prev=0).
